// File: rtl/prefetch_ctrl_if.sv
// Instruction-bus request/response and fetch-fifo write-side signals of the prefetch controller.
// Signal names carry the controller's point of view; the master modport is the controller side.
interface prefetch_ctrl_if;
    logic        req_o;
    logic [31:0] addr_o;
    logic        ack_i;
    logic        rvalid_i;
    logic        fifo_flush_o;
    logic        fifo_wr_o;
    logic        fifo_rd_i;

    modport master (
        output req_o, addr_o, fifo_flush_o, fifo_wr_o,
        input  ack_i, rvalid_i, fifo_rd_i
    );

    modport slave (
        input  req_o, addr_o, fifo_flush_o, fifo_wr_o,
        output ack_i, rvalid_i, fifo_rd_i
    );
endinterface

// File: rtl/prefetch_ctrl.sv
// Instruction prefetch sequencer: in-order word reads gated by fifo/outstanding credit, jump redirect
// with kill tracking of old-stream responses. Optional drop statistics under PREFETCH_CTRL_STATS_EN.
module prefetch_ctrl #(
    parameter int unsigned C_FIFO_DEPTH_X = 2,
    parameter int unsigned C_MAX_OUTST_X  = 1,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            resetb_i,
    input  logic            clk_en_i,
    input  logic            jump_i,
    input  logic [31:0]     jump_addr_i,
    prefetch_ctrl_if.master bus_if,
    output logic [15:0]     stat_kill_o
);
    localparam int unsigned OW = C_FIFO_DEPTH_X + 1;
    localparam int unsigned CW = C_MAX_OUTST_X + 1;
    localparam int unsigned D  = 2 ** C_FIFO_DEPTH_X;
    localparam int unsigned M  = 2 ** C_MAX_OUTST_X;

    typedef enum logic [1:0] {S_BOOT, S_WAIT, S_REQ} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] kill_q, kill_d;
    logic          stale_q, stale_d;

    logic ack_e, rv_e, jmp_e, rd_e, wr_e, drop_e;
    logic credit_q, credit_d;

    function automatic logic credit_f(logic [OW-1:0] occ, logic [CW-1:0] live, logic [CW-1:0] kill);
        return ((32'(occ) + 32'(live)) < D) && ((32'(live) + 32'(kill)) < M);
    endfunction

    // Qualified events: nothing advances while the clock enable is low.
    assign ack_e  = clk_en_i && (state_q == S_REQ) && bus_if.ack_i;
    assign rv_e   = clk_en_i && bus_if.rvalid_i;
    assign jmp_e  = clk_en_i && jump_i;
    assign rd_e   = clk_en_i && bus_if.fifo_rd_i && !jump_i;
    assign wr_e   = rv_e && (kill_q == '0) && !jump_i;
    assign drop_e = rv_e && !wr_e;

    assign bus_if.fifo_flush_o = jump_i;
    assign bus_if.fifo_wr_o    = bus_if.rvalid_i && (kill_q == '0) && !jump_i;
    assign bus_if.req_o        = (state_q == S_REQ);
    assign bus_if.addr_o       = req_addr_q;

    assign credit_q = credit_f(occ_q, live_q, kill_q);
    assign credit_d = credit_f(occ_d, live_d, kill_d);

    always_comb begin
        occ_d   = occ_q;
        live_d  = live_q;
        kill_d  = kill_q;
        stale_d = stale_q;
        pc_d    = pc_q;
        if (jmp_e) begin
            // Everything in flight, including a same-cycle ack, now belongs to the dead stream.
            occ_d  = '0;
            live_d = '0;
            kill_d = kill_q + live_q + CW'(ack_e) - CW'(rv_e);
            pc_d   = jump_addr_i;
            if (ack_e) begin
                stale_d = 1'b0;
            end else if (state_q == S_REQ) begin
                stale_d = 1'b1;
            end
        end else begin
            occ_d  = occ_q + OW'(wr_e) - OW'(rd_e);
            live_d = live_q + CW'(ack_e && !stale_q) - CW'(wr_e);
            kill_d = kill_q + CW'(ack_e && stale_q) - CW'(drop_e);
            if (ack_e) begin
                stale_d = 1'b0;
                // A stale ack completes the pre-jump address; pc already holds the target.
                if (!stale_q) begin
                    pc_d = pc_q + 32'd4;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        if (clk_en_i) begin
            case (state_q)
                S_BOOT, S_WAIT: begin
                    if (credit_q) begin
                        state_d    = S_REQ;
                        req_addr_d = pc_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_REQ: begin
                    if (ack_e) begin
                        if (credit_d) begin
                            req_addr_d = pc_d;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= S_BOOT;
            pc_q       <= C_RESET_VECTOR;
            req_addr_q <= C_RESET_VECTOR;
            occ_q      <= '0;
            live_q     <= '0;
            kill_q     <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            occ_q      <= occ_d;
            live_q     <= live_d;
            kill_q     <= kill_d;
            stale_q    <= stale_d;
        end
    end

`ifdef PREFETCH_CTRL_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (drop_e && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            stat_q <= 16'h0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_kill_o = stat_q;
`else
    assign stat_kill_o = 16'h0;
`endif
endmodule

// File: tb/tb_prefetch_ctrl.sv
// Randomised bench for prefetch_ctrl: a bus/fifo model drives stimulus and queues expectations,
// a monitor pops them whenever the DUT presents a request or a response cycle.
module tb_prefetch_ctrl;
    localparam int D = 4;
    localparam int M = 2;

    typedef struct {
        logic [31:0] addr;
        bit          killed;
        int          due;
    } rd_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic        clk_en;
    logic        jump;
    logic [31:0] jump_addr;
    logic [15:0] stat_kill;

    always #5 clk = ~clk;

    prefetch_ctrl_if bif();

    prefetch_ctrl #(
        .C_FIFO_DEPTH_X(2),
        .C_MAX_OUTST_X (1),
        .C_RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk_i      (clk),
        .resetb_i   (resetb),
        .clk_en_i   (clk_en),
        .jump_i     (jump),
        .jump_addr_i(jump_addr),
        .bus_if     (bif),
        .stat_kill_o(stat_kill)
    );

    // Reference model: reads in flight on the bus, fifo fill, expected stream address.
    rd_t         inflight[$];
    logic [31:0] exp_addr_q[$];
    bit          exp_wr_q[$];
    logic [31:0] exp_next, pend_addr;
    bit          pend, pend_killed, prev_credit;
    int          occ_m, drops_m, drops_before, cyc;
    int          errors = 0;
    int          checks = 0;
    int          n_acks, n_wr;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit credit_m();
        int live = 0;
        int kill = 0;
        foreach (inflight[i]) begin
            if (inflight[i].killed) kill++;
            else live++;
        end
        return ((occ_m + live) < D) && ((live + kill) < M);
    endfunction

    function automatic logic [15:0] exp_stat();
`ifdef PREFETCH_CTRL_STATS_EN
        return 16'(drops_before);
`else
        return 16'h0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0;
        clk_en = 1'b1; jump = 1'b0; jump_addr = 32'h0;
        bif.ack_i = 1'b0; bif.rvalid_i = 1'b0; bif.fifo_rd_i = 1'b0;
        inflight.delete(); exp_addr_q.delete(); exp_wr_q.delete();
        exp_next = 32'h0; pend = 0; pend_killed = 0; prev_credit = 0;
        occ_m = 0; drops_m = 0; drops_before = 0;
        #2;
        check("rst_req_o", {31'h0, bif.req_o}, 32'h0);
        check("rst_addr_o", bif.addr_o, 32'h0);
        check("rst_stat", {16'h0, stat_kill}, 32'h0);
        @(negedge clk);
        #2;
        check("rst_fifo_wr_o", {31'h0, bif.fifo_wr_o}, 32'h0);
        resetb = 1'b1;
    endtask

    // One bus cycle: choose inputs, push expectations, advance the model past the next edge.
    task automatic step(int ack_pct, int lat_max, int rd_pct, int jmp_pct, int en_pct,
                        logic [31:0] jt = 32'h1);
        bit          en, a, j, rv, rd, cr, wr;
        rd_t         e;
        logic [31:0] r, jaddr;
        @(negedge clk);
        cyc++;
        drops_before = drops_m;
        en = ($urandom_range(99) < en_pct);
        cr = credit_m();
        if (prev_credit && cr) check("req_on_credit", {31'h0, bif.req_o}, 32'h1);
        if (bif.req_o) check("req_has_credit", {31'h0, cr}, 32'h1);
        r = $urandom();
        jaddr = {r[31:2], 2'b00};
        if ($urandom_range(3) == 0) jaddr = 32'hFFFF_FFF8;
        if (jt != 32'h1) jaddr = jt;
        a  = en && bif.req_o && ($urandom_range(99) < ack_pct);
        j  = en && ($urandom_range(99) < jmp_pct);
        rv = en && (inflight.size() > 0) && (inflight[0].due <= cyc);
        rd = en && !j && (occ_m > 0) && ($urandom_range(99) < rd_pct);
        clk_en = en; jump = j; jump_addr = jaddr;
        bif.ack_i = a; bif.rvalid_i = rv; bif.fifo_rd_i = rd;
        if (bif.req_o) begin
            if (!pend) begin
                pend = 1; pend_killed = 0; pend_addr = exp_next;
            end
            exp_addr_q.push_back(pend_addr);
        end
        if (rv) begin
            e  = inflight.pop_front();
            wr = !e.killed && !j;
            exp_wr_q.push_back(wr);
            if (wr) occ_m++;
            else drops_m++;
        end
        if (rd) occ_m--;
        if (j) begin
            foreach (inflight[i]) inflight[i].killed = 1;
            if (pend) pend_killed = 1;
            exp_next = jaddr;
        end
        if (a) begin
            e.addr = pend_addr;
            e.killed = pend_killed;
            e.due = cyc + $urandom_range(lat_max, 1);
            if (!e.killed) exp_next = pend_addr + 32'd4;
            inflight.push_back(e);
            pend = 0;
            n_acks++;
        end
        if (j) occ_m = 0;
        prev_credit = en && cr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bif.req_o) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL addr_o: unexpected request at 0x%08h (cycle %0d)", bif.addr_o, cyc);
                end else begin
                    check("addr_o", bif.addr_o, exp_addr_q.pop_front());
                end
            end
            if (bif.rvalid_i) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fifo_wr_o: response with nothing expected (cycle %0d)", cyc);
                end else begin
                    check("fifo_wr_o", {31'h0, bif.fifo_wr_o}, {31'h0, exp_wr_q.pop_front()});
                end
            end else begin
                check("fifo_wr_idle", {31'h0, bif.fifo_wr_o}, 32'h0);
            end
            check("fifo_flush_o", {31'h0, bif.fifo_flush_o}, {31'h0, jump});
            if (bif.fifo_wr_o) n_wr++;
        end
    end

    initial begin
        cyc = 0;
        resetb = 1'b0;

        // Boot with an always-acking bus and no consumer: exactly four reads fill the fifo.
        do_reset();
        n_acks = 0; n_wr = 0;
        repeat (14) step(100, 1, 0, 0, 100);
        check("t1_reqs", n_acks, 32'd4);
        check("t1_writes", n_wr, 32'd4);
        check("t1_req_idle", {31'h0, bif.req_o}, 32'h0);

        // Held request (including enable-low cycles), then stale jump to the top of memory.
        do_reset();
        repeat (5) step(0, 1, 0, 0, 100);
        repeat (2) step(0, 1, 0, 0, 0);
        check("t2_req_held", {31'h0, bif.req_o}, 32'h1);
        step(100, 1, 0, 0, 100);
        step(0, 1, 0, 100, 100, 32'hFFFF_FFFC);
        repeat (8) step(100, 1, 50, 0, 100);
        check("t4_stat", {16'h0, stat_kill}, {16'h0, exp_stat()});

        // Randomised traffic, with an asynchronous reset dropped in mid-stream.
        repeat (1500) step(60, 3, 40, 8, 90);
        check("rnd1_stat", {16'h0, stat_kill}, {16'h0, exp_stat()});
        do_reset();
        repeat (1500) step(80, 1, 70, 3, 100);
        check("rnd2_stat", {16'h0, stat_kill}, {16'h0, exp_stat()});
        repeat (800) step(100, 4, 20, 15, 80);
        check("rnd3_stat", {16'h0, stat_kill}, {16'h0, exp_stat()});

        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
